// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module : uart_tx_arbiter
// Brief  : Round-robin, packet-granular sharing of one UART byte transmitter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active
);

    localparam int         c_idw       = $clog2(NUM_REQ);
    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_idw-1:0]        r_rr_ptr;
    logic [c_idw-1:0]        r_grant_id;
    logic                    r_grant_active;
    logic [7:0]              r_burst_cnt;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_start;

    logic                    w_found;
    logic [c_idw-1:0]        w_pick;
    logic [NUM_REQ-1:0]      w_ready;
    logic                    w_hs;
    logic [DATA_WIDTH-1:0]   w_byte;

    // Search starts just after the last released requester and wraps.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = c_idw'(idx);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_GRANT && !tx_busy) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign w_hs   = (r_state == S_GRANT) && !tx_busy && req_valid[r_grant_id];
    assign w_byte = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= c_idw'(NUM_REQ - 1);
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_burst_cnt    <= '0;
            r_last         <= 1'b0;
            r_tx_data      <= '0;
            r_tx_start     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id     <= w_pick;
                        r_grant_active <= 1'b1;
                        r_burst_cnt    <= '0;
                        r_state        <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_hs) begin
                        r_tx_data   <= w_byte;
                        r_tx_start  <= 1'b1;
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                        // Packet end and burst limit collapse into one release.
                        r_last      <= req_last[r_grant_id] ||
                                       (r_burst_cnt + 8'd1 == c_max_burst);
                        r_state     <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_last) begin
                            r_rr_ptr       <= r_grant_id;
                            r_grant_active <= 1'b0;
                            r_state        <= S_IDLE;
                        end else begin
                            r_state <= S_GRANT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = w_ready;
    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign grant_id     = r_grant_id;
    assign grant_active = r_grant_active;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged last, or until MAX_BURST bytes have gone out.
- Sits between the requester FIFOs/FSMs and the transmitter. It sequences the transmitter's start/busy handshake so that bytes never overlap on the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, bits per UART character.
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  byte is final of packet.
- req_ready  output  NUM_REQ  one-hot byte accept (combinational from state).
- tx_data  output  DATA_WIDTH  byte to transmitter, held stable while tx_busy.
- tx_start  output  1  one-cycle pulse launching a character.
- tx_busy  input  1  transmitter busy. Rises the cycle after tx_start; falls after the stop bit.
- grant_id  output  $clog2(NUM_REQ)  currently granted requester.
- grant_active  output  1  a grant is held.

Behaviour:
- Reset:
  - state=IDLE; req_ready=0; tx_start=0; tx_data=0; grant_id=0; grant_active=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority; burst_cnt=0.
- IDLE:
  - If any req_valid, pick the first set bit searching from (rr_ptr+1) mod NUM_REQ, upward with wrap.
  - Register grant_id, set grant_active=1, burst_cnt=0, go GRANT. Arbitration costs 1 cycle.
- GRANT:
  - req_ready[grant_id] = !tx_busy; all other req_ready=0.
  - Handshake when req_valid[grant_id] && req_ready[grant_id]. On handshake:
    - tx_data<=byte; tx_start<=1 for exactly the next cycle.
    - burst_cnt<=burst_cnt+1; latch last_flag = req_last[grant_id] || (burst_cnt+1 == MAX_BURST).
    - Go WAIT_ACK.
  - If req_valid[grant_id] is low: stay in GRANT, hold the grant. The requester may pause mid-packet.
- WAIT_ACK:
  - Exactly 1 cycle (tx_start high); tx_busy is ignored.
  - Go WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_busy==0.
  - If last_flag: rr_ptr<=grant_id, grant_active<=0, go IDLE.
  - Otherwise go GRANT.
  - Minimum gap between tx_start pulses = 1 character time + 2 cycles.
- req_ready is never asserted outside GRANT. At most one bit is set.
- Requester behaviour:
  - Deasserting req_valid of a non-granted requester has no effect.
  - Deasserting req_valid of the granted requester only stalls.
- rst mid-character:
  - Controller returns to reset values the next cycle; the in-flight byte is abandoned by the controller.
  - The transmitter's own behaviour under reset is outside this block.
- req_last with burst_cnt at MAX_BURST-1: both release causes coincide; only a single release occurs.
- MAX_BURST=1 gives byte-level round-robin.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43).
  - Exactly 3 tx_start pulses with matching tx_data.
  - req_ready[0] high only while tx_busy low.
  - grant_active drops after the 3rd tx_busy fall.
- Contention: req 1 and req 2 both valid with 2-byte packets from reset.
  - Req 1 granted first, both bytes complete; then req 2.
  - No interleaving of bytes; rr_ptr=2 at end.
- Fairness wrap: after a req 3 packet, req 0 and req 3 are valid.
  - Req 0 wins (search starts at 0).
  - Req 3 wins next.
- Burst limit: MAX_BURST=4; req 0 streams 10 bytes with no last, req 1 waiting.
  - Req 0 is released after 4 bytes; req 1 gets the grant.
  - Req 0 is re-granted afterwards.
- Stall and busy: granted req 0 drops req_valid for 20 cycles mid-packet.
  - Grant is held; no tx_start is issued.
  - Resumed byte starts only after tx_busy is low.
- Reset mid-character: assert rst while tx_busy is high.
  - Next cycle: all outputs 0, state IDLE.
  - First grant after reset goes to req 0.
